// File: rtl/ro_measure_pkg.sv
// ro_measure_pkg
//  Shared types and constants for the ring-oscillator measurement sequencer.
//  - state_t       : sequencer state encoding
//  - CLK_SRC_*     : clock-source select codes driven onto clk_source
package ro_measure_pkg;

  typedef enum logic [2:0] {
    IDLE,
    SHIFT,
    SETTLE,
    MEASURE,
    DONE
  } state_t;

  localparam logic [2:0] CLK_SRC_DIV4 = 3'd0;  // clk divided by 4
  localparam logic [2:0] CLK_SRC_RO3  = 3'd1;  // 3-stage ring oscillator
  localparam logic [2:0] CLK_SRC_RO5  = 3'd2;  // 5-stage ring oscillator
  localparam logic [2:0] CLK_SRC_RAW  = 3'd3;  // undivided clk

endpackage

// File: rtl/ro_edge_sync.sv
// ro_edge_sync
//  Brings the asynchronous ro_clk into the clk domain through a two-flop
//  synchronizer plus one delay flop and flags each rising edge for one cycle.
//  Ports:
//   clk    in  system clock
//   rst    in  asynchronous reset, active high (clears all flops)
//   ro_clk in  macro clock, asynchronous to clk
//   rise   out one-cycle pulse per synchronized rising edge of ro_clk
module ro_edge_sync (
  input  logic clk,
  input  logic rst,
  input  logic ro_clk,
  output logic rise
);

  // sync_reg[0..1] form the synchronizer, sync_reg[2] is the delay flop
  logic [2:0] sync_reg;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) sync_reg[0] <= 1'b0;
    else     sync_reg[0] <= ro_clk;
  end

  for (genvar gi = 1; gi < 3; gi++) begin : g_stage
    always_ff @(posedge clk or posedge rst) begin
      if (rst) sync_reg[gi] <= 1'b0;
      else     sync_reg[gi] <= sync_reg[gi-1];
    end
  end

  assign rise = sync_reg[1] & ~sync_reg[2];

endmodule

// File: rtl/ro_measure_ctrl.sv
// ro_measure_ctrl
//  Sequencer for the ring-oscillator test macro: shifts the config chain out
//  MSB first, selects the clock source, releases the macro counter reset,
//  lets the synchronizer settle, then counts ro_clk rising edges over a fixed
//  window of clk cycles and reports the (saturating) count.
//  Ports:
//   clk, rst              system clock, asynchronous active-high reset
//   start, abort          request / cancel (abort wins)
//   cfg_word, cfg_sel     chain contents and clock select, sampled on start
//   ro_clk                macro clock under test (asynchronous)
//   shift_clk, shift_dta  config chain shift clock and serial data
//   clk_source, ro_rst    macro clock select and counter reset
//   busy, done            activity flag and one-cycle completion pulse
//   count, ovf            result of the last completed window
module ro_measure_ctrl
  import ro_measure_pkg::*;
#(
  parameter int CFG_W      = 128,
  parameter int SHIFT_DIV  = 4,
  parameter int SETTLE_CYC = 16,
  parameter int WIN_CYC    = 1024,
  parameter int CNT_W      = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic             abort,
  input  logic [CFG_W-1:0] cfg_word,
  input  logic [2:0]       cfg_sel,
  input  logic             ro_clk,
  output logic             shift_clk,
  output logic             shift_dta,
  output logic [2:0]       clk_source,
  output logic             ro_rst,
  output logic             busy,
  output logic             done,
  output logic [CNT_W-1:0] count,
  output logic             ovf
);

  localparam int DIV_W = $clog2(SHIFT_DIV + 1);
  localparam int BIT_W = $clog2(CFG_W + 1);
  localparam int SET_W = $clog2(SETTLE_CYC + 1);
  localparam int WIN_W = $clog2(WIN_CYC + 1);

  localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(SHIFT_DIV - 1);
  localparam logic [BIT_W-1:0] BIT_LAST = BIT_W'(CFG_W - 1);
  localparam logic [SET_W-1:0] SET_LAST = SET_W'(SETTLE_CYC - 1);
  localparam logic [WIN_W-1:0] WIN_LAST = WIN_W'(WIN_CYC - 1);
  localparam logic [CNT_W-1:0] CNT_MAX  = '1;

  state_t             state_reg, state_next;
  logic [CFG_W-1:0]   shift_reg;
  logic [DIV_W-1:0]   div_reg;
  logic               phase_reg;      // 0 = shift_clk low half, 1 = high half
  logic [BIT_W-1:0]   bit_reg;
  logic [SET_W-1:0]   settle_reg;
  logic [WIN_W-1:0]   win_reg;
  logic [CNT_W-1:0]   edge_cnt_reg, edge_cnt_next;
  logic               sat_reg, sat_next;
  logic               rise;
  logic               half_end, bit_end;

  ro_edge_sync u_sync (
    .clk    (clk),
    .rst    (rst),
    .ro_clk (ro_clk),
    .rise   (rise)
  );

  assign half_end = (div_reg == DIV_LAST);
  assign bit_end  = half_end & phase_reg;

  // Saturating edge count including the edge seen in the current cycle, so
  // the final window cycle can be folded straight into count/ovf.
  always_comb begin
    edge_cnt_next = edge_cnt_reg;
    sat_next      = sat_reg;
    if (rise) begin
      if (edge_cnt_reg == CNT_MAX) sat_next = 1'b1;
      else                         edge_cnt_next = edge_cnt_reg + CNT_W'(1);
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state_reg <= IDLE;
    else     state_reg <= state_next;
  end

  always_comb begin
    state_next = state_reg;
    shift_clk  = 1'b0;
    shift_dta  = 1'b0;
    ro_rst     = 1'b0;
    busy       = 1'b1;
    done       = 1'b0;
    case (state_reg)
      IDLE: begin
        busy   = 1'b0;
        ro_rst = 1'b1;
        if (start) state_next = SHIFT;
      end
      SHIFT: begin
        ro_rst    = 1'b1;
        shift_clk = phase_reg;
        shift_dta = shift_reg[CFG_W-1];
        if (bit_end && bit_reg == BIT_LAST) state_next = SETTLE;
      end
      SETTLE: begin
        if (settle_reg == SET_LAST) state_next = MEASURE;
      end
      MEASURE: begin
        if (win_reg == WIN_LAST) state_next = DONE;
      end
      DONE: begin
        done       = 1'b1;
        state_next = IDLE;
      end
      default: state_next = IDLE;
    endcase
    if (abort) state_next = IDLE;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      shift_reg    <= '0;
      div_reg      <= '0;
      phase_reg    <= 1'b0;
      bit_reg      <= '0;
      settle_reg   <= '0;
      win_reg      <= '0;
      edge_cnt_reg <= '0;
      sat_reg      <= 1'b0;
      clk_source   <= '0;
      count        <= '0;
      ovf          <= 1'b0;
    end else if (abort) begin
      div_reg    <= '0;
      phase_reg  <= 1'b0;
      bit_reg    <= '0;
      settle_reg <= '0;
      win_reg    <= '0;
    end else begin
      case (state_reg)
        IDLE: begin
          if (start) begin
            shift_reg  <= cfg_word;
            clk_source <= cfg_sel;
            div_reg    <= '0;
            phase_reg  <= 1'b0;
            bit_reg    <= '0;
          end
        end
        SHIFT: begin
          settle_reg <= '0;
          if (half_end) begin
            div_reg   <= '0;
            phase_reg <= ~phase_reg;
            if (phase_reg) begin
              shift_reg <= {shift_reg[CFG_W-2:0], 1'b0};
              bit_reg   <= bit_reg + BIT_W'(1);
            end
          end else begin
            div_reg <= div_reg + DIV_W'(1);
          end
        end
        SETTLE: begin
          settle_reg   <= settle_reg + SET_W'(1);
          win_reg      <= '0;
          edge_cnt_reg <= '0;
          sat_reg      <= 1'b0;
        end
        MEASURE: begin
          win_reg      <= win_reg + WIN_W'(1);
          edge_cnt_reg <= edge_cnt_next;
          sat_reg      <= sat_next;
          // Publish on entry to DONE so count/ovf are already valid while
          // done is high.
          if (win_reg == WIN_LAST) begin
            count <= edge_cnt_next;
            ovf   <= sat_next;
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_ro_measure_ctrl.sv
module tb_ro_measure_ctrl;

  localparam int CFG_W      = 8;
  localparam int SHIFT_DIV  = 1;
  localparam int SETTLE_CYC = 4;
  localparam int WIN_CYC    = 64;
  localparam int SHIFT_N    = CFG_W * 2 * SHIFT_DIV;   // cycles in chain shifting
  localparam int MEAS_N     = SHIFT_N + SETTLE_CYC;    // first window cycle
  localparam int DONE_N     = MEAS_N + WIN_CYC;        // done cycle
  localparam int HN         = 1024;

  logic             clk = 1'b0;
  logic             rst = 1'b1;
  logic             start = 1'b0;
  logic             abort = 1'b0;
  logic             ro_clk = 1'b0;
  logic [CFG_W-1:0] cfg_word = '0;
  logic [2:0]       cfg_sel = '0;

  logic        shift_clk, shift_dta, ro_rst, busy, done, ovf;
  logic [2:0]  clk_source;
  logic [15:0] count;
  logic        shift_clk_s, shift_dta_s, ro_rst_s, busy_s, done_s, ovf_s;
  logic [2:0]  clk_source_s;
  logic [3:0]  count_s;

  ro_measure_ctrl #(.CFG_W(CFG_W), .SHIFT_DIV(SHIFT_DIV), .SETTLE_CYC(SETTLE_CYC),
                    .WIN_CYC(WIN_CYC), .CNT_W(16)) dut (
    .clk(clk), .rst(rst), .start(start), .abort(abort), .cfg_word(cfg_word),
    .cfg_sel(cfg_sel), .ro_clk(ro_clk), .shift_clk(shift_clk), .shift_dta(shift_dta),
    .clk_source(clk_source), .ro_rst(ro_rst), .busy(busy), .done(done),
    .count(count), .ovf(ovf));

  ro_measure_ctrl #(.CFG_W(CFG_W), .SHIFT_DIV(SHIFT_DIV), .SETTLE_CYC(SETTLE_CYC),
                    .WIN_CYC(WIN_CYC), .CNT_W(4)) dut_s (
    .clk(clk), .rst(rst), .start(start), .abort(abort), .cfg_word(cfg_word),
    .cfg_sel(cfg_sel), .ro_clk(ro_clk), .shift_clk(shift_clk_s), .shift_dta(shift_dta_s),
    .clk_source(clk_source_s), .ro_rst(ro_rst_s), .busy(busy_s), .done(done_s),
    .count(count_s), .ovf(ovf_s));

  always #5 clk = ~clk;

  int total = 0;
  int bad = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0d expected %0d (t=%0t)", name, act, exp, $time);
    end
  endtask

  // ro_clk source: square wave of period 2*ro_half clk cycles, changing on
  // the falling clk edge so sampling at the rising edge is unambiguous.
  int ro_half = 0;
  int ro_ph = 0;
  always @(negedge clk) begin
    if (ro_half == 0) begin
      ro_clk = 1'b0;
      ro_ph  = 0;
    end else begin
      ro_ph++;
      if (ro_ph >= ro_half) begin
        ro_ph  = 0;
        ro_clk = ~ro_clk;
      end
    end
  end

  // Reference model: a run is a timeline of cycle offsets from the accepted
  // start; the result is the number of synchronized rising edges falling in
  // the window, clipped to the counter range.
  int               cyc = 0;
  bit               active = 0;
  int               t0 = 0;
  logic [CFG_W-1:0] cfg_m = '0;
  logic [2:0]       src_m = '0;
  int               cnt_m = 0, cnt_sm = 0;
  bit               ovf_m = 0, ovf_sm = 0;
  bit               hist [0:HN-1];

  always @(posedge clk or posedge rst) begin
    if (rst) begin
      active = 0;
      cnt_m  = 0;
      cnt_sm = 0;
      ovf_m  = 0;
      ovf_sm = 0;
      src_m  = '0;
      for (int i = 0; i < HN; i++) hist[i] = 1'b0;
    end else begin
      int n, edges;
      cyc++;
      hist[cyc % HN] = ro_clk;
      if (abort) begin
        active = 0;
      end else if (!active) begin
        if (start) begin
          active = 1;
          t0     = cyc;
          cfg_m  = cfg_word;
          src_m  = cfg_sel;
        end
      end else begin
        n = cyc - t0;
        if (n == DONE_N) begin
          // edge visible in the cycle after edge k is ro_clk(k-1) & ~ro_clk(k-2)
          edges = 0;
          for (int k = t0 + MEAS_N; k < t0 + DONE_N; k++)
            if (hist[(k-1) % HN] && !hist[(k-2) % HN]) edges++;
          cnt_m  = (edges > 65535) ? 65535 : edges;
          ovf_m  = (edges > 65535);
          cnt_sm = (edges > 15) ? 15 : edges;
          ovf_sm = (edges > 15);
        end else if (n == DONE_N + 1) begin
          active = 0;
        end
      end
    end
  end

  // Cycle-by-cycle comparison against the model.
  always @(negedge clk) begin
    int  n, idx;
    bit  sh, e_sc, e_sd;
    n    = cyc - t0;
    sh   = active && (n < SHIFT_N);
    e_sc = 0;
    e_sd = 0;
    if (sh) begin
      idx  = CFG_W - 1 - n / (2 * SHIFT_DIV);
      e_sc = ((n / SHIFT_DIV) % 2) == 1;
      e_sd = cfg_m[idx];
    end
    chk("busy",        32'(busy),         32'(active));
    chk("done",        32'(done),         32'(active && n == DONE_N));
    chk("ro_rst",      32'(ro_rst),       32'(!active || n < SHIFT_N));
    chk("shift_clk",   32'(shift_clk),    32'(e_sc));
    chk("shift_dta",   32'(shift_dta),    32'(e_sd));
    chk("clk_source",  32'(clk_source),   32'(src_m));
    chk("count",       32'(count),        32'(cnt_m));
    chk("ovf",         32'(ovf),          32'(ovf_m));
    chk("s_busy",      32'(busy_s),       32'(active));
    chk("s_done",      32'(done_s),       32'(active && n == DONE_N));
    chk("s_ro_rst",    32'(ro_rst_s),     32'(!active || n < SHIFT_N));
    chk("s_shift_clk", 32'(shift_clk_s),  32'(e_sc));
    chk("s_shift_dta", 32'(shift_dta_s),  32'(e_sd));
    chk("s_clk_src",   32'(clk_source_s), 32'(src_m));
    chk("s_count",     32'(count_s),      32'(cnt_sm));
    chk("s_ovf",       32'(ovf_s),        32'(ovf_sm));
  end

  // Observation of shift_clk rises and done pulses for literal checks.
  logic [7:0] cap = '0;
  int         rises = 0;
  int         done_pulses = 0;
  logic       prev_sc = 1'b0;
  always @(negedge clk) begin
    if (shift_clk === 1'b1 && prev_sc === 1'b0) begin
      cap = {cap[6:0], shift_dta};
      rises++;
    end
    prev_sc = shift_clk;
    if (done === 1'b1) done_pulses++;
  end

  task automatic pulse_start(input logic [7:0] cfg, input logic [2:0] sel);
    @(negedge clk);
    cfg_word = cfg;
    cfg_sel  = sel;
    start    = 1'b1;
    @(negedge clk);
    start    = 1'b0;
  endtask

  // Waits for done; lat counts falling edges from the one that raised start.
  task automatic wait_done(input int already, output int lat);
    lat = already;
    while (done !== 1'b1 && lat < 400) begin
      @(negedge clk);
      lat++;
    end
    if (done !== 1'b1) chk("done_timeout", 32'(lat), 32'(DONE_N + 1));
  endtask

  initial begin
    int lat, dp;
    #100000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int lat, dp;
    repeat (3) @(negedge clk);
    chk("rst_count",     32'(count),      32'd0);
    chk("rst_ro_rst",    32'(ro_rst),     32'd1);
    chk("rst_busy",      32'(busy),       32'd0);
    chk("rst_shift_clk", 32'(shift_clk),  32'd0);
    rst = 1'b0;

    // clk/4 ro_clk, 0xA5 chain
    ro_half = 2;
    cap = '0;
    rises = 0;
    pulse_start(8'hA5, 3'd1);
    wait_done(1, lat);
    chk("latency",   32'(lat),     32'd85);
    chk("chain_bits", 32'(cap),    32'hA5);
    chk("rises",     32'(rises),   32'd8);
    chk("count16",   32'(count),   32'd16);
    chk("ovf16",     32'(ovf),     32'd0);
    chk("count4",    32'(count_s), 32'd15);
    chk("ovf4",      32'(ovf_s),   32'd1);
    repeat (2) @(negedge clk);
    chk("idle_shift_clk", 32'(shift_clk), 32'd0);

    // abort while shifting bit 3
    dp = done_pulses;
    pulse_start(8'h3C, 3'd2);
    repeat (6) @(negedge clk);
    chk("pre_abort_busy", 32'(busy), 32'd1);
    abort = 1'b1;
    @(negedge clk);
    abort = 1'b0;
    chk("abort_shift_clk", 32'(shift_clk), 32'd0);
    chk("abort_busy",      32'(busy),      32'd0);
    chk("abort_ro_rst",    32'(ro_rst),    32'd1);
    chk("abort_count",     32'(count),     32'd16);
    repeat (100) @(negedge clk);
    chk("abort_no_done",   32'(done_pulses - dp), 32'd0);
    chk("abort_src",       32'(clk_source),       32'd2);

    // period-6 ro_clk, second start during MEASURE is ignored
    ro_half = 3;
    dp = done_pulses;
    pulse_start(8'h0F, 3'd3);
    repeat (30) @(negedge clk);
    cfg_sel = 3'd5;
    start   = 1'b1;
    @(negedge clk);
    start   = 1'b0;
    wait_done(32, lat);
    repeat (10) @(negedge clk);
    chk("single_done",  32'(done_pulses - dp),             32'd1);
    chk("src_first",    32'(clk_source),                   32'd3);
    chk("count_p6",     32'(count == 16'd10 || count == 16'd11), 32'd1);

    // clk/2 ro_clk: one edge every two cycles
    ro_half = 1;
    pulse_start(8'hFF, 3'd0);
    wait_done(1, lat);
    chk("count_fast",   32'(count),   32'd32);
    chk("count4_fast",  32'(count_s), 32'd15);

    // asynchronous reset in the middle of the window
    ro_half = 2;
    pulse_start(8'h5A, 3'd2);
    repeat (40) @(negedge clk);
    #3 rst = 1'b1;
    #1;
    chk("arst_count",     32'(count),      32'd0);
    chk("arst_ovf",       32'(ovf),        32'd0);
    chk("arst_busy",      32'(busy),       32'd0);
    chk("arst_ro_rst",    32'(ro_rst),     32'd1);
    chk("arst_clk_src",   32'(clk_source), 32'd0);
    chk("arst_done",      32'(done),       32'd0);
    chk("arst_shift_clk", 32'(shift_clk),  32'd0);
    @(negedge clk);
    rst = 1'b0;
    pulse_start(8'h5A, 3'd2);
    wait_done(1, lat);
    chk("post_rst_latency", 32'(lat),   32'd85);
    chk("post_rst_count",   32'(count), 32'd16);
    repeat (3) @(negedge clk);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
